// File: rtl/reg_bank_bus_ctrl.sv
// reg_bank_bus_ctrl
//   Upstream controller for a bank of tri-state register flip-flops that share
//   one D (write) bus and one Q (read) bus. Commands arrive over a valid/ready
//   handshake; the controller sequences per-register load enables, output
//   selects and preset strobes. Reads insert a turnaround cycle so no two
//   registers ever drive Q in consecutive cycles.
//
// Ports
//   Clock, Reset      system clock (rising edge), async active-high reset
//   Tick              global tick; registers load only on ClockEnable & Tick
//   req_valid/ready   command handshake
//   req_op            00 read, 01 write, 10 preset, 11 reserved (error)
//   req_addr          target register index
//   req_wdata         write data
//   rsp_valid         one-cycle pulse, rsp_rdata holds the read result
//   rsp_rdata         last read result, held until the next read completes
//   rsp_err           one-cycle pulse for out-of-range address or op 11
//   ClockEnable       one-hot load enable per register
//   D                 shared write data bus
//   cs                per-register output select, 0 = drives Q, 1 = high-Z
//   pre               per-register preset strobe (sets all ones)
//   Q                 shared read bus from the registers
module reg_bank_bus_ctrl #(
  parameter int unsigned NrOfBits = 8,
  parameter int unsigned NrOfRegs = 4,
  parameter int unsigned AddrBits = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [AddrBits-1:0] req_addr,
  input  logic [NrOfBits-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [NrOfBits-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic [NrOfRegs-1:0] ClockEnable,
  output logic [NrOfBits-1:0] D,
  output logic [NrOfRegs-1:0] cs,
  output logic [NrOfRegs-1:0] pre,
  input  logic [NrOfBits-1:0] Q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_PRESET,
    S_RD_EN,
    S_RD_CAP,
    S_TURN
  } state_e;

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [NrOfBits-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [NrOfRegs-1:0] ce_q, ce_d;
  logic [NrOfBits-1:0] d_q, d_d;
  logic [NrOfRegs-1:0] cs_q, cs_d;
  logic [NrOfRegs-1:0] pre_q, pre_d;

  logic [NrOfRegs-1:0] addr_oh;
  logic                addr_bad;

  // Out-of-range addresses decode to an all-zero one-hot.
  always_comb begin
    addr_oh = '0;
    for (int unsigned i = 0; i < NrOfRegs; i++) begin
      if (32'(req_addr) == i) addr_oh[i] = 1'b1;
    end
    addr_bad = (32'(req_addr) >= NrOfRegs);
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ce_d        = ce_q;
    d_d         = d_q;
    cs_d        = cs_q;
    pre_d       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (addr_bad || req_op == 2'b11) begin
            rsp_err_d = 1'b1;
          end else begin
            case (req_op)
              2'b00: begin
                cs_d        = ~addr_oh;
                req_ready_d = 1'b0;
                state_d     = S_RD_EN;
              end
              2'b01: begin
                d_d         = req_wdata;
                ce_d        = addr_oh;
                req_ready_d = 1'b0;
                state_d     = S_WRITE;
              end
              2'b10: begin
                pre_d       = addr_oh;
                req_ready_d = 1'b0;
                state_d     = S_PRESET;
              end
              default: ;
            endcase
          end
        end
      end
      S_WRITE: begin
        // The register loads on this same edge, so drop the enable with it.
        if (Tick) begin
          ce_d        = '0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_PRESET: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_RD_EN: begin
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        rsp_rdata_d = Q;
        rsp_valid_d = 1'b1;
        cs_d        = '1;
        state_d     = S_TURN;
      end
      S_TURN: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        ce_d        = '0;
        cs_d        = '1;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ce_q        <= '0;
      d_q         <= '0;
      cs_q        <= '1;
      pre_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ce_q        <= ce_d;
      d_q         <= d_d;
      cs_q        <= cs_d;
      pre_q       <= pre_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign ClockEnable = ce_q;
  assign D           = d_q;
  assign cs          = cs_q;
  assign pre         = pre_q;

endmodule
